// File: rtl/spi_minion_shift_ctrl_if.sv
// Strobe/status bundle between the SPI minion sequencer and its parent datapath.
// The master side drives the raw pins and the parent handshakes.
interface spi_minion_shift_ctrl_if #(
  parameter int unsigned nbits = 8
);
  localparam int unsigned CntW = $clog2(nbits);

  logic            cs;
  logic            sclk;
  logic            push_rdy;
  logic            pull_val;
  logic            rx_shift_en;
  logic            tx_load_en;
  logic            tx_shift_en;
  logic            push_en;
  logic            pull_en;
  logic [CntW-1:0] bit_cnt;
  logic            busy;
  logic            overrun;
  logic            underflow;
  logic            abort;

  modport master (
    output cs, sclk, push_rdy, pull_val,
    input  rx_shift_en, tx_load_en, tx_shift_en, push_en, pull_en,
    input  bit_cnt, busy, overrun, underflow, abort
  );

  modport slave (
    input  cs, sclk, push_rdy, pull_val,
    output rx_shift_en, tx_load_en, tx_shift_en, push_en, pull_en,
    output bit_cnt, busy, overrun, underflow, abort
  );
endinterface

// File: rtl/spi_minion_shift_ctrl.sv
// SPI mode-0 minion sequencer: synchronizes cs/sclk, counts bits and issues
// load/shift strobes for the rx/tx shift registers plus push/pull handshakes.
module spi_minion_shift_ctrl #(
  parameter int unsigned nbits = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  spi_minion_shift_ctrl_if.slave   bus
);
  localparam int unsigned CntW = $clog2(nbits);

  typedef enum logic [1:0] {ARM, IDLE, ACTIVE} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            word_done_q, word_done_d;
  logic            flushed_q;

  logic cs_s1_q, cs_s_q, cs_d_q;
  logic sclk_s1_q, sclk_s_q, sclk_d_q;

  logic rx_shift_q, rx_shift_d;
  logic tx_load_q, tx_load_d;
  logic tx_shift_q, tx_shift_d;
  logic push_q, push_d;
  logic pull_q, pull_d;
  logic ovr_q, ovr_d;
  logic und_q, und_d;
  logic abt_q, abt_d;

  logic cs_fall, cs_rise, sclk_pos, sclk_neg;

  // Two-flop synchronizers plus one history flop per pin
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_s1_q   <= 1'b1;
      cs_s_q    <= 1'b1;
      cs_d_q    <= 1'b1;
      sclk_s1_q <= 1'b0;
      sclk_s_q  <= 1'b0;
      sclk_d_q  <= 1'b0;
      flushed_q <= 1'b0;
    end else begin
      cs_s1_q   <= bus.cs;
      cs_s_q    <= cs_s1_q;
      cs_d_q    <= cs_s_q;
      sclk_s1_q <= bus.sclk;
      sclk_s_q  <= sclk_s1_q;
      sclk_d_q  <= sclk_s_q;
      flushed_q <= 1'b1;
    end
  end

  assign sclk_pos = sclk_s_q & ~sclk_d_q;
  assign sclk_neg = ~sclk_s_q & sclk_d_q;
  assign cs_fall  = ~cs_s_q & cs_d_q;
  assign cs_rise  = cs_s_q & ~cs_d_q;

  // State, counter and registered strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARM;
      cnt_q       <= '0;
      word_done_q <= 1'b0;
      rx_shift_q  <= 1'b0;
      tx_load_q   <= 1'b0;
      tx_shift_q  <= 1'b0;
      push_q      <= 1'b0;
      pull_q      <= 1'b0;
      ovr_q       <= 1'b0;
      und_q       <= 1'b0;
      abt_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_done_q <= word_done_d;
      rx_shift_q  <= rx_shift_d;
      tx_load_q   <= tx_load_d;
      tx_shift_q  <= tx_shift_d;
      push_q      <= push_d;
      pull_q      <= pull_d;
      ovr_q       <= ovr_d;
      und_q       <= und_d;
      abt_q       <= abt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_done_d = 1'b0;
    rx_shift_d  = 1'b0;
    tx_load_d   = 1'b0;
    tx_shift_d  = 1'b0;
    push_d      = 1'b0;
    pull_d      = 1'b0;
    ovr_d       = 1'b0;
    und_d       = 1'b0;
    abt_d       = 1'b0;

    // Completed word: hand it off and preload the next tx word
    if (word_done_q) begin
      push_d    = bus.push_rdy;
      ovr_d     = ~bus.push_rdy;
      tx_load_d = 1'b1;
      pull_d    = 1'b1;
      und_d     = ~bus.pull_val;
    end

    case (state_q)
      // The cs chain resets high, so wait until the live pin has reached it
      ARM: begin
        if (flushed_q && cs_s1_q && cs_s_q) state_d = IDLE;
      end
      IDLE: begin
        if (cs_fall) begin
          tx_load_d = 1'b1;
          pull_d    = 1'b1;
          und_d     = ~bus.pull_val;
          cnt_d     = '0;
          state_d   = ACTIVE;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          cnt_d   = '0;
          abt_d   = (cnt_q != '0);
        end else if (sclk_pos) begin
          rx_shift_d = 1'b1;
          if (cnt_q == CntW'(nbits - 1)) begin
            cnt_d       = '0;
            word_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end else if (sclk_neg && (cnt_q != '0)) begin
          tx_shift_d = 1'b1;
        end
      end
      default: state_d = ARM;
    endcase
  end

  assign bus.rx_shift_en = rx_shift_q;
  assign bus.tx_load_en  = tx_load_q;
  assign bus.tx_shift_en = tx_shift_q;
  assign bus.push_en     = push_q;
  assign bus.pull_en     = pull_q;
  assign bus.overrun     = ovr_q;
  assign bus.underflow   = und_q;
  assign bus.abort       = abt_q;
  assign bus.bit_cnt     = cnt_q;
  assign bus.busy        = (state_q == ACTIVE);
endmodule

// File: tb/tb_spi_minion_shift_ctrl.sv
// Directed bench for spi_minion_shift_ctrl: counts strobes per scenario and
// compares against hand-derived totals.
module tb_spi_minion_shift_ctrl;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  spi_minion_shift_ctrl_if #(.nbits(8)) bus ();

  spi_minion_shift_ctrl #(.nbits(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // strobe index: 0 rx,1 txl,2 txs,3 push,4 pull,5 ovr,6 und,7 abt
  int cnt [8];
  int base[8];
  int n_und_ld = 0;
  int n_excl   = 0;
  int n_wide   = 0;
  logic [7:0] prev = '0;
  int errors = 0;
  int checks = 0;

  function automatic logic [7:0] strobes();
    return {bus.abort, bus.underflow, bus.overrun, bus.pull_en,
            bus.push_en, bus.tx_shift_en, bus.tx_load_en, bus.rx_shift_en};
  endfunction

  initial for (int i = 0; i < 8; i++) cnt[i] = 0;

  always @(negedge clk) begin
    logic [7:0] s;
    s = strobes();
    for (int i = 0; i < 8; i++) begin
      if (s[i] === 1'b1) cnt[i]++;
      if (s[i] === 1'b1 && prev[i] === 1'b1 && !reset) n_wide++;
    end
    if (s[1] && s[6]) n_und_ld++;
    if (s[1] && s[2]) n_excl++;
    prev = s;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    for (int i = 0; i < 8; i++) base[i] = cnt[i];
  endtask

  function automatic int dlt(input int i);
    return cnt[i] - base[i];
  endfunction

  task automatic pulse(input int n);
    repeat (n) begin
      bus.sclk = 1'b1;
      tick(5);
      bus.sclk = 1'b0;
      tick(5);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.cs = 1'b1;
    bus.sclk = 1'b0;
    bus.push_rdy = 1'b1;
    bus.pull_val = 1'b1;
    tick(3);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_bitcnt", 32'(bus.bit_cnt), 0);
    chk("rst_strobes", 32'(strobes()), 0);
    reset = 1'b0;
    tick(5);

    // single 8-bit word
    snap();
    bus.cs = 1'b0;
    tick(6);
    chk("w1_load", 32'(dlt(1)), 1);
    chk("w1_pull", 32'(dlt(4)), 1);
    chk("w1_und", 32'(dlt(6)), 0);
    chk("w1_busy", 32'(bus.busy), 1);
    pulse(3);
    chk("w1_bitcnt3", 32'(bus.bit_cnt), 3);
    pulse(5);
    chk("w1_rx", 32'(dlt(0)), 8);
    chk("w1_txs", 32'(dlt(2)), 7);
    chk("w1_push", 32'(dlt(3)), 1);
    chk("w1_load2", 32'(dlt(1)), 2);
    chk("w1_bitcnt0", 32'(bus.bit_cnt), 0);
    chk("w1_ovr", 32'(dlt(5)), 0);
    bus.cs = 1'b1;
    tick(6);
    chk("w1_abort", 32'(dlt(7)), 0);
    chk("w1_idle", 32'(bus.busy), 0);

    // two back-to-back words
    snap();
    bus.cs = 1'b0;
    tick(6);
    pulse(7);
    chk("b2b_bitcnt7", 32'(bus.bit_cnt), 7);
    pulse(1);
    chk("b2b_wrap", 32'(bus.bit_cnt), 0);
    pulse(8);
    chk("b2b_push", 32'(dlt(3)), 2);
    chk("b2b_load", 32'(dlt(1)), 3);
    chk("b2b_rx", 32'(dlt(0)), 16);
    chk("b2b_txs", 32'(dlt(2)), 14);
    bus.cs = 1'b1;
    tick(6);

    // abort after 3 bits, then a clean frame
    snap();
    bus.cs = 1'b0;
    tick(6);
    pulse(3);
    bus.cs = 1'b1;
    tick(6);
    chk("abt_pulse", 32'(dlt(7)), 1);
    chk("abt_nopush", 32'(dlt(3)), 0);
    chk("abt_bitcnt", 32'(bus.bit_cnt), 0);
    chk("abt_busy", 32'(bus.busy), 0);
    snap();
    bus.cs = 1'b0;
    tick(6);
    pulse(8);
    bus.cs = 1'b1;
    tick(6);
    chk("abt_next_push", 32'(dlt(3)), 1);
    chk("abt_next_abort", 32'(dlt(7)), 0);

    // overrun, then a normal push
    snap();
    bus.push_rdy = 1'b0;
    bus.cs = 1'b0;
    tick(6);
    pulse(8);
    chk("ovr_pulse", 32'(dlt(5)), 1);
    chk("ovr_nopush", 32'(dlt(3)), 0);
    bus.push_rdy = 1'b1;
    snap();
    pulse(8);
    chk("ovr_next_push", 32'(dlt(3)), 1);
    chk("ovr_next_ovr", 32'(dlt(5)), 0);
    bus.cs = 1'b1;
    tick(6);

    // underflow at cs fall
    snap();
    bus.pull_val = 1'b0;
    bus.cs = 1'b0;
    tick(6);
    chk("und_pulse", 32'(dlt(6)), 1);
    chk("und_with_load", 32'(n_und_ld), 1);
    bus.pull_val = 1'b1;
    pulse(8);
    chk("und_preload_ok", 32'(dlt(6)), 1);

    // reset mid-transfer with cs held low and sclk running
    pulse(2);
    bus.sclk = 1'b1;
    reset = 1'b1;
    tick(1);
    chk("mid_rst_strobes", 32'(strobes()), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_bitcnt", 32'(bus.bit_cnt), 0);
    tick(2);
    reset = 1'b0;
    bus.sclk = 1'b0;
    tick(5);
    snap();
    pulse(8);
    chk("arm_silent", 32'(dlt(0) + dlt(1) + dlt(2) + dlt(3) + dlt(4)), 0);
    chk("arm_busy", 32'(bus.busy), 0);
    bus.cs = 1'b1;
    tick(6);
    snap();
    bus.cs = 1'b0;
    tick(6);
    pulse(8);
    bus.cs = 1'b1;
    tick(6);
    chk("arm_then_rx", 32'(dlt(0)), 8);
    chk("arm_then_push", 32'(dlt(3)), 1);

    chk("excl_load_shift", 32'(n_excl), 0);
    chk("strobe_width", 32'(n_wide), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
